conv_14_15_acc_requant: RTL

//  Downstream consumer of the conv_14_15 signed 16x8 product multiplier.

---
 rtl/conv_14_15_acc_requant.sv | 93 +++++++++
 1 files changed

// File: rtl/conv_14_15_acc_requant.sv
// Accumulates KLEN signed products per output, then requantizes with a shift and saturation.
// Optional CONV_ACC_ROUND_EN: round half up before the shift instead of flooring.
module conv_14_15_acc_requant #(
  parameter int IN_W  = 24,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int KLEN  = 9,
  parameter int SHIFT = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(KLEN - 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0]        acc;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        ext;
  logic [ACC_W-1:0]        sum;
  logic signed [ACC_W:0]   wide;
  logic signed [ACC_W:0]   q;
  logic [OUT_W-1:0]        q_dat;
  logic                    q_sat;
  logic                    accept;
  logic                    last;

  assign in_ready = !ap_rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST);

  assign ext  = ACC_W'($signed(in_data));
  // The first beat of a kernel ignores acc so no explicit clear cycle is needed.
  assign sum  = ((cnt == '0) ? '0 : acc) + ext;
  assign wide = $signed({sum[ACC_W-1], sum});

`ifdef CONV_ACC_ROUND_EN
  localparam logic [ACC_W:0] HALF =
    (SHIFT == 0) ? '0 : ((ACC_W+1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
  assign q = (wide + $signed(HALF)) >>> SHIFT;
`else
  assign q = wide >>> SHIFT;
`endif

  always_comb begin
    q_sat = 1'b0;
    q_dat = q[OUT_W-1:0];
    if (q > MAXV) begin
      q_sat = 1'b1;
      q_dat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (q < MINV) begin
      q_sat = 1'b1;
      q_dat = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A final beat overrides the clear above so results can go back to back.
      if (accept) begin
        if (last) begin
          out_data  <= q_dat;
          out_sat   <= q_sat;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
